window_avg_reader: RTL and testbench

- Consumer side of the 8-stage sample shift register.
- Each time a new sample enters a full window, the block freezes the register by driving its active-low enable high. It then reads the taps serially, one per cycle, into a signed accumulator.
- It emits the window sum and the floor mean with a one-cycle valid pulse. The result feeds the downstream feature/threshold logic.

---
 rtl/window_avg_reader.sv | 101 ++++++++++
 tb/tb_window_avg_reader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/window_avg_reader.sv
// rtl/window_avg_reader.sv - freezes the sample shift register and serially sums its taps into a window sum and floor mean
module window_avg_reader #(
  parameter int input_width = 37,
  parameter int reg_depth   = 8,
  parameter int log2_depth  = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 data_ready,
  input  logic                                 window_valid,
  input  logic [input_width*reg_depth-1:0]     taps,
  output logic                                 sr_hold,
  output logic                                 busy,
  output logic signed [input_width+log2_depth-1:0] sum_out,
  output logic signed [input_width-1:0]        avg_out,
  output logic                                 result_valid,
  output logic                                 overrun
);

  localparam int acc_width = input_width + log2_depth;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                        state, state_next;
  logic                          pending;
  logic [log2_depth-1:0]         idx;
  logic signed [acc_width-1:0]   acc;
  logic signed [acc_width-1:0]   acc_sum;
  logic signed [input_width-1:0] tap_sel;
  logic                          start;
  logic                          last;

  always_comb begin
    tap_sel = '0;
    for (int k = 0; k < reg_depth; k++) begin
      if (idx == k[log2_depth-1:0]) tap_sel = taps[k*input_width +: input_width];
    end
  end

  assign acc_sum = acc + {{log2_depth{tap_sel[input_width-1]}}, tap_sel};
  assign start   = (state == IDLE) && pending && window_valid;
  assign last    = (state == ACCUM) && (idx == log2_depth'(reg_depth - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // sr_hold rises combinationally with start so the register freezes in the start cycle itself
  always_comb begin
    state_next = state;
    sr_hold    = 1'b0;
    case (state)
      IDLE: begin
        sr_hold = start;
        if (start) state_next = ACCUM;
      end
      ACCUM: begin
        sr_hold = 1'b1;
        if (last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (rst) sr_hold = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending      <= 1'b0;
      idx          <= '0;
      acc          <= '0;
      busy         <= 1'b0;
      sum_out      <= '0;
      avg_out      <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (data_ready && sr_hold) overrun <= 1'b1;
      if (start)                         pending <= 1'b0;
      else if (data_ready && !sr_hold)   pending <= 1'b1;

      if (start) begin
        acc  <= '0;
        idx  <= '0;
        busy <= 1'b1;
      end else if (state == ACCUM) begin
        acc <= acc_sum;
        idx <= idx + 1'b1;
        if (last) begin
          // upper bits of the sum are the arithmetic right shift by log2_depth
          sum_out      <= acc_sum;
          avg_out      <= acc_sum[acc_width-1:log2_depth];
          result_valid <= 1'b1;
          busy         <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_window_avg_reader.sv
// tb/tb_window_avg_reader.sv - scoreboard bench for window_avg_reader with a shift-register environment model
module tb_window_avg_reader;
  localparam int W = 37;
  localparam int D = 8;
  localparam int L = 3;
  localparam int BIG = 1000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic data_ready = 1'b0;
  logic window_valid;
  logic [W*D-1:0] taps;
  logic sr_hold, busy, result_valid, overrun;
  logic signed [W+L-1:0] sum_out;
  logic signed [W-1:0] avg_out;

  window_avg_reader #(.input_width(W), .reg_depth(D), .log2_depth(L)) dut (
    .clk(clk), .rst(rst), .data_ready(data_ready), .window_valid(window_valid),
    .taps(taps), .sr_hold(sr_hold), .busy(busy), .sum_out(sum_out),
    .avg_out(avg_out), .result_valid(result_valid), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // environment: the 8-stage shift register with active-low enable
  logic signed [W-1:0] sample = '0;
  logic signed [W-1:0] sr [D] = '{default: '0};
  int sr_cnt = 0;
  always @(posedge clk) begin
    if (data_ready && !sr_hold) begin
      for (int k = D - 1; k > 0; k--) sr[k] <= sr[k-1];
      sr[0] <= sample;
      if (sr_cnt < D) sr_cnt <= sr_cnt + 1;
    end
  end
  assign window_valid = (sr_cnt >= D);
  always_comb begin
    for (int k = 0; k < D; k++) taps[k*W +: W] = sr[k];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { longint sum; longint avg; int cyc; } exp_t;
  exp_t   sb[$];
  longint hist[$];
  int     hold_lo = BIG, hold_hi = -1, ovr_cyc = BIG;
  longint last_sum = 0, last_avg = 0;
  int     checks = 0, errors = 0;
  int     run = 0, last_run = 0;
  exp_t   mon_e;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint floor_div(input longint s);
    longint q;
    q = s / D;
    if ((s % D) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  function automatic longint rand_samp();
    longint v;
    v = longint'({$urandom, $urandom});
    v = (v <<< (64 - W)) >>> (64 - W);
    return v;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // drives one strobe and updates the reference model from the cycle it lands in
  task automatic issue(input longint val);
    int c;
    longint s;
    exp_t e;
    c = cyc;
    data_ready = 1'b1;
    sample = val[W-1:0];
    if (c >= hold_lo && c <= hold_hi) begin
      if (ovr_cyc > c + 1) ovr_cyc = c + 1;
    end else begin
      hist.push_back(val);
      if (hist.size() > D) void'(hist.pop_front());
      if (hist.size() == D) begin
        s = 0;
        foreach (hist[i]) s += hist[i];
        e.sum = s;
        e.avg = floor_div(s);
        e.cyc = c + D + 2;
        sb.push_back(e);
        hold_lo = c + 1;
        hold_hi = c + D + 1;
      end
    end
    @(posedge clk);
    #1;
    data_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    int r;
    r = cyc;
    rst = 1'b1;
    #1;
    chk("sr_hold_in_rst", sr_hold, 0);
    if (hold_hi > r) hold_hi = r;
    ovr_cyc = BIG;
    while (sb.size() > 0 && sb[$].cyc > r) void'(sb.pop_back());
    last_sum = 0;
    last_avg = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("sr_hold", sr_hold, (cyc >= hold_lo && cyc <= hold_hi) ? 1 : 0);
      chk("busy", busy, (cyc >= hold_lo + 1 && cyc <= hold_hi) ? 1 : 0);
      chk("overrun", overrun, (cyc >= ovr_cyc) ? 1 : 0);
      if (result_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("result_cycle", cyc, mon_e.cyc);
          chk("sum_out", sum_out, mon_e.sum);
          chk("avg_out", avg_out, mon_e.avg);
          last_sum = mon_e.sum;
          last_avg = mon_e.avg;
        end
      end else begin
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
          chk("missing_result", 0, 1);
          void'(sb.pop_front());
        end
        chk("sum_hold", sum_out, last_sum);
        chk("avg_hold", avg_out, last_avg);
      end
      if (sr_hold) run++;
      else if (run > 0) begin
        last_run = run;
        run = 0;
      end
    end else begin
      run = 0;
    end
  end

  initial begin
    longint maxp;
    maxp = (64'sd1 <<< 36) - 1;
    idle(3);
    rst = 1'b0;
    chk("reset_sum", sum_out, 0);
    chk("reset_busy", busy, 0);

    for (int i = 0; i < 7; i++) begin
      issue(rand_samp());
      idle(11);
    end

    for (int i = 0; i < 8; i++) begin
      issue(10);
      if (i < 7) idle(11);
    end
    idle(10);
    chk("tens_sum", sum_out, 80);
    chk("tens_avg", avg_out, 10);
    chk("tens_hold_len", last_run, 9);
    idle(1);

    issue(-2);
    idle(11);
    for (int i = 0; i < 7; i++) begin
      issue(-1);
      idle(11);
    end
    chk("neg_sum", sum_out, -9);
    chk("neg_avg", avg_out, -2);

    for (int i = 0; i < 8; i++) begin
      issue(maxp);
      idle(11);
    end
    chk("max_sum", sum_out, 8 * maxp);
    chk("max_avg", avg_out, maxp);

    issue(rand_samp());
    idle(3);
    issue(rand_samp());
    idle(7);
    issue(rand_samp());
    idle(11);
    chk("overrun_sticky", overrun, 1);

    issue(rand_samp());
    idle(4);
    pulse_reset();
    chk("rst_sum", sum_out, 0);
    chk("rst_overrun", overrun, 0);
    idle(10);
    issue(rand_samp());
    idle(11);

    for (int i = 1; i <= 27; i++) begin
      issue(i);
      idle(9);
      if (i == 16) begin
        chk("ramp_valid", result_valid, 1);
        chk("ramp_sum", sum_out, 100);
        chk("ramp_avg", avg_out, 12);
      end
    end
    chk("ramp_overrun", overrun, 0);

    for (int i = 0; i < 12; i++) begin
      issue(rand_samp());
      idle($urandom_range(9, 13));
    end

    idle(15);
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
